// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and timing constants for the tile sequencer.
// Rev 1.0
`default_nettype none

package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_e;

  localparam int MAC_LAT_DEFAULT = 4;
  localparam int RD_LAT_DEFAULT  = 1;

  // Cycles after the last issue until the far-corner PE has absorbed its last term.
  function automatic int flush_len(input int rows, input int cols,
                                   input int rd_lat, input int mac_lat);
    return ((rows < cols) ? rows : cols) - 1 + rd_lat + mac_lat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skew_delay.sv
// skew_delay: resettable WIDTH-bit shift register of DEPTH stages (DEPTH >= 1).
// Rev 1.0
`default_nettype none

module skew_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: issues skewed operand reads and row-edge en/clr for an
// output-stationary MAC array, waits for the pipeline to flush, then drains rows.
`default_nettype none

module systolic_tile_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MAX_K   = 256,
  parameter int AW      = $clog2(MAX_K),
  parameter int RD_LAT  = RD_LAT_DEFAULT,
  parameter int MAC_LAT = MAC_LAT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [AW:0]              k_len,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic [ROWS-1:0]          x_rd_en,
  output logic [ROWS*AW-1:0]       x_rd_addr,
  output logic [COLS-1:0]          w_rd_en,
  output logic [COLS*AW-1:0]       w_rd_addr,
  output logic [ROWS-1:0]          row_en,
  output logic [ROWS-1:0]          row_clr,
  output logic                     drain_valid,
  input  logic                     drain_ready,
  output logic [$clog2(ROWS)-1:0]  drain_row
);

  localparam int LANES     = (ROWS > COLS) ? ROWS : COLS;
  localparam int FLUSH_CYC = flush_len(ROWS, COLS, RD_LAT, MAC_LAT);
  localparam int CW        = $clog2(MAX_K + LANES + FLUSH_CYC) + 1;
  localparam int RDW       = $clog2(ROWS);

  ctrl_state_e    state, state_n;
  logic [AW:0]    k_reg, k_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [RDW-1:0] row_q, row_n;
  logic           cfg_err_q, cfg_err_n;

  logic [CW-1:0]  kx;
  logic [CW-1:0]  issue_last;
  logic           k_ok;
  logic [ROWS-1:0] x_first;

  assign kx         = CW'(k_reg);
  assign issue_last = kx + CW'(LANES - 2);
  assign k_ok       = (k_len != '0) && (k_len <= (AW+1)'(MAX_K));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      cnt       <= '0;
      row_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      k_reg     <= k_n;
      cnt       <= cnt_n;
      row_q     <= row_n;
      cfg_err_q <= cfg_err_n;
    end
  end

  always_comb begin
    state_n   = state;
    k_n       = k_reg;
    cnt_n     = cnt;
    row_n     = row_q;
    cfg_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (k_ok) begin
            k_n     = k_len;
            cnt_n   = '0;
            state_n = ISSUE;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cnt == issue_last) begin
          cnt_n   = '0;
          state_n = FLUSH;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FLUSH: begin
        if (cnt == CW'(FLUSH_CYC - 1)) begin
          cnt_n   = '0;
          row_n   = '0;
          state_n = DRAIN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_ready) begin
          if (row_q == RDW'(ROWS - 1)) begin
            row_n   = '0;
            state_n = DONE;
          end else begin
            row_n = row_q + RDW'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Lane r serves term (cnt - r) while that term index lies in [0, K).
  for (genvar r = 0; r < ROWS; r++) begin : g_x_lane
    logic [CW-1:0] rel;
    assign rel        = cnt - CW'(r);
    assign x_rd_en[r] = (state == ISSUE) && (cnt >= CW'(r)) && (rel < kx);
    assign x_rd_addr[r*AW +: AW] = x_rd_en[r] ? rel[AW-1:0] : '0;
    assign x_first[r] = x_rd_en[r] && (rel == '0);
  end

  for (genvar c = 0; c < COLS; c++) begin : g_w_lane
    logic [CW-1:0] rel;
    assign rel        = cnt - CW'(c);
    assign w_rd_en[c] = (state == ISSUE) && (cnt >= CW'(c)) && (rel < kx);
    assign w_rd_addr[c*AW +: AW] = w_rd_en[c] ? rel[AW-1:0] : '0;
  end

  // Align en/clr with the operand data returned by the buffers.
  skew_delay #(
    .WIDTH(2 * ROWS),
    .DEPTH(RD_LAT)
  ) u_row_dly (
    .clk (clk),
    .rst (rst),
    .din ({x_first, x_rd_en}),
    .dout({row_clr, row_en})
  );

  assign busy        = (state == ISSUE) || (state == FLUSH) || (state == DRAIN);
  assign done        = (state == DONE);
  assign drain_valid = (state == DRAIN);
  assign drain_row   = row_q;
  assign cfg_err     = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_tile_ctrl.sv
// tb_systolic_tile_ctrl: drives a behavioural MAC array from the controller and
// checks drained rows against a golden matrix product plus key cycle timings.
`default_nettype none

module tb_systolic_tile_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int MAX_K = 256;
  localparam int AW    = 8;
  localparam int ML    = 4;

  logic                clk = 1'b0;
  logic                rst, start, drain_ready;
  logic [AW:0]         k_len;
  logic                busy, done, cfg_err, drain_valid;
  logic [ROWS-1:0]     x_rd_en, row_en, row_clr;
  logic [COLS-1:0]     w_rd_en;
  logic [ROWS*AW-1:0]  x_rd_addr;
  logic [COLS*AW-1:0]  w_rd_addr;
  logic [1:0]          drain_row;

  systolic_tile_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .MAX_K(MAX_K), .AW(AW), .RD_LAT(1), .MAC_LAT(ML)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .row_en(row_en), .row_clr(row_clr),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_row(drain_row)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int done_cnt = 0, cfg_cnt = 0;

  typedef struct { int row; logic [127:0] data; } exp_t;
  exp_t sb[$];

  // Operand buffers and a 4-stage output-stationary MAC array fed by the DUT.
  byte xbuf [ROWS][MAX_K];
  byte wbuf [COLS][MAX_K];
  byte xd [ROWS];
  byte wd [COLS];
  byte xh [ROWS][COLS];
  byte wv [ROWS][COLS];
  logic enh [ROWS][COLS];
  logic clrh [ROWS][COLS];
  byte px [ROWS][COLS];
  byte pw [ROWS][COLS];
  logic pen [ROWS][COLS];
  logic pclr [ROWS][COLS];
  logic s_en [ROWS][COLS][ML-1];
  logic s_clr [ROWS][COLS][ML-1];
  int   s_prod [ROWS][COLS][ML-1];
  int   acc [ROWS][COLS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        px[r][c]   = (c == 0) ? xd[r] : xh[r][c];
        pen[r][c]  = (c == 0) ? row_en[r] : enh[r][c];
        pclr[r][c] = (c == 0) ? row_clr[r] : clrh[r][c];
        pw[r][c]   = (r == 0) ? wd[c] : wv[r][c];
      end
    end
  end

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++)
      xd[r] <= x_rd_en[r] ? xbuf[r][x_rd_addr[r*AW +: AW]] : 8'sd0;
    for (int c = 0; c < COLS; c++)
      wd[c] <= w_rd_en[c] ? wbuf[c][w_rd_addr[c*AW +: AW]] : 8'sd0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rst) begin
          xh[r][c] <= 0; wv[r][c] <= 0; enh[r][c] <= 1'b0; clrh[r][c] <= 1'b0;
          acc[r][c] <= 0;
          for (int i = 0; i < ML-1; i++) begin
            s_en[r][c][i] <= 1'b0; s_clr[r][c][i] <= 1'b0; s_prod[r][c][i] <= 0;
          end
        end else begin
          if (c > 0) begin
            xh[r][c]   <= px[r][c-1];
            enh[r][c]  <= pen[r][c-1];
            clrh[r][c] <= pclr[r][c-1];
          end
          if (r > 0) wv[r][c] <= pw[r-1][c];
          s_en[r][c][0]   <= pen[r][c];
          s_clr[r][c][0]  <= pclr[r][c];
          s_prod[r][c][0] <= int'(px[r][c]) * int'(pw[r][c]);
          for (int i = 1; i < ML-1; i++) begin
            s_en[r][c][i]   <= s_en[r][c][i-1];
            s_clr[r][c][i]  <= s_clr[r][c][i-1];
            s_prod[r][c][i] <= s_prod[r][c][i-1];
          end
          if (s_en[r][c][ML-2])
            acc[r][c] <= s_clr[r][c][ML-2] ? s_prod[r][c][ML-2]
                                           : acc[r][c] + s_prod[r][c][ML-2];
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted drain row is popped from the scoreboard and compared.
  initial begin
    logic [127:0] v;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (drain_valid && drain_ready) begin
          for (int c = 0; c < COLS; c++) v[c*32 +: 32] = acc[drain_row][c];
          if (sb.size() == 0) begin
            check("drain_unexpected", 128'd1, 128'd0);
          end else begin
            e = sb.pop_front();
            check("drain_row_idx", 128'(drain_row), 128'(e.row));
            check("drain_row_data", v, e.data);
          end
        end
        if (done) done_cnt++;
        if (cfg_err) cfg_cnt++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive_at(input int n);
    wait_to(n - 1);
    next_cycle();
  endtask

  task automatic prep_job(input int k);
    exp_t e;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < k; i++) xbuf[r][i] = byte'($urandom_range(0, 255));
    for (int c = 0; c < COLS; c++)
      for (int i = 0; i < k; i++) wbuf[c][i] = byte'($urandom_range(0, 255));
    for (int r = 0; r < ROWS; r++) begin
      e.row  = r;
      e.data = '0;
      for (int c = 0; c < COLS; c++) begin
        int s = 0;
        for (int i = 0; i < k; i++) s += int'(xbuf[r][i]) * int'(wbuf[c][i]);
        e.data[c*32 +: 32] = s;
      end
      sb.push_back(e);
    end
  endtask

  task automatic start_cmd(input int k);
    start = 1'b1;
    k_len = (AW+1)'(k);
    next_cycle();
    start = 1'b0;
  endtask

  task automatic run_job(input int k, input bit rnd);
    int dc0 = done_cnt;
    int n = 0;
    prep_job(k);
    start = 1'b1;
    k_len = (AW+1)'(k);
    while (done_cnt == dc0 && n < k + 200) begin
      next_cycle();
      start = 1'b0;
      drain_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      n++;
    end
    check("job_done_count", 128'(done_cnt - dc0), 128'd1);
    check("job_sb_empty", 128'(sb.size()), 128'd0);
    drain_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, dc0, cc0;
    rst = 1'b1; start = 1'b0; k_len = '0; drain_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          128'({busy, done, cfg_err, x_rd_en, w_rd_en, row_en, row_clr,
                drain_valid, drain_row, x_rd_addr, w_rd_addr}), 128'd0);
    next_cycle();
    rst = 1'b0;

    // K=3 nominal timing
    dc0 = done_cnt;
    prep_job(3);
    t0 = cyc;
    start_cmd(3);
    wait_to(t0 + 1);
    check("k3_x0_t1", 128'({x_rd_en[0], x_rd_addr[7:0]}), 128'({1'b1, 8'd0}));
    check("k3_busy_t1", 128'(busy), 128'd1);
    wait_to(t0 + 2);
    check("k3_x0_t2", 128'({x_rd_en[0], x_rd_addr[7:0]}), 128'({1'b1, 8'd1}));
    check("k3_clr0_t2", 128'({row_clr[0], row_en[0]}), 128'b11);
    wait_to(t0 + 3);
    check("k3_x0_t3", 128'({x_rd_en[0], x_rd_addr[7:0]}), 128'({1'b1, 8'd2}));
    check("k3_clr0_t3", 128'({row_clr[0], row_en[0]}), 128'b01);
    check("k3_w2_t3", 128'({w_rd_en[2], w_rd_addr[23:16]}), 128'({1'b1, 8'd0}));
    check("k3_x3_t3", 128'(x_rd_en[3]), 128'd0);
    wait_to(t0 + 4);
    check("k3_x0_t4", 128'({x_rd_en[0], x_rd_addr[7:0]}), 128'd0);
    check("k3_x3_t4", 128'({x_rd_en[3], x_rd_addr[31:24]}), 128'({1'b1, 8'd0}));
    wait_to(t0 + 6);
    check("k3_x3_t6", 128'({x_rd_en[3], x_rd_addr[31:24]}), 128'({1'b1, 8'd2}));
    wait_to(t0 + 7);
    check("k3_idle_lanes_t7", 128'({x_rd_en, w_rd_en}), 128'd0);
    wait_to(t0 + 14);
    check("k3_valid_t14", 128'(drain_valid), 128'd0);
    wait_to(t0 + 15);
    check("k3_valid_t15", 128'({drain_valid, drain_row}), 128'({1'b1, 2'd0}));
    wait_to(t0 + 18);
    check("k3_t18", 128'({busy, done, drain_row}), 128'({1'b1, 1'b0, 2'd3}));
    wait_to(t0 + 19);
    check("k3_done_t19", 128'({busy, done}), 128'b01);
    wait_to(t0 + 20);
    check("k3_done_t20", 128'(done), 128'd0);
    check("k3_done_count", 128'(done_cnt - dc0), 128'd1);

    // K=3 with backpressure for the first 5 drain cycles
    next_cycle();
    prep_job(3);
    t0 = cyc;
    drain_ready = 1'b0;
    start_cmd(3);
    wait_to(t0 + 15);
    check("bp_valid_t15", 128'({drain_valid, drain_row}), 128'({1'b1, 2'd0}));
    wait_to(t0 + 17);
    check("bp_hold_t17", 128'({drain_valid, drain_row}), 128'({1'b1, 2'd0}));
    wait_to(t0 + 19);
    check("bp_hold_t19", 128'({busy, drain_valid, drain_row}), 128'({2'b11, 2'd0}));
    next_cycle();
    drain_ready = 1'b1;
    wait_to(t0 + 23);
    check("bp_t23", 128'({done, drain_row}), 128'({1'b0, 2'd3}));
    wait_to(t0 + 24);
    check("bp_done_t24", 128'({busy, done}), 128'b01);

    // invalid depths: 0 and MAX_K+1
    for (int j = 0; j < 2; j++) begin
      next_cycle();
      cc0 = cfg_cnt;
      t0 = cyc;
      start_cmd((j == 0) ? 0 : MAX_K + 1);
      wait_to(t0 + 1);
      check("cfg_err_t1", 128'({cfg_err, busy, x_rd_en, w_rd_en}), 128'({1'b1, 9'd0}));
      wait_to(t0 + 2);
      check("cfg_err_t2", 128'({cfg_err, busy, x_rd_en, w_rd_en}), 128'd0);
      check("cfg_err_count", 128'(cfg_cnt - cc0), 128'd1);
    end

    // start pulses during ISSUE and DRAIN are ignored
    next_cycle();
    dc0 = done_cnt;
    cc0 = cfg_cnt;
    prep_job(5);
    t0 = cyc;
    start_cmd(5);
    drive_at(t0 + 4);
    start = 1'b1; k_len = '0;
    drive_at(t0 + 5);
    start = 1'b0;
    drive_at(t0 + 18);
    start = 1'b1; k_len = (AW+1)'(2);
    drive_at(t0 + 19);
    start = 1'b0;
    wait_to(t0 + 21);
    check("ign_done_t21", 128'({busy, done}), 128'b01);
    wait_to(t0 + 24);
    check("ign_done_count", 128'(done_cnt - dc0), 128'd1);
    check("ign_cfg_count", 128'(cfg_cnt - cc0), 128'd0);
    check("ign_idle", 128'({busy, x_rd_en}), 128'd0);

    // reset during FLUSH aborts; a K=1 job afterwards completes normally
    next_cycle();
    dc0 = done_cnt;
    prep_job(2);
    t0 = cyc;
    start_cmd(2);
    drive_at(t0 + 8);
    rst = 1'b1;
    sb.delete();
    wait_to(t0 + 9);
    check("rst_flush_outputs",
          128'({busy, done, cfg_err, x_rd_en, w_rd_en, row_en, row_clr,
                drain_valid, drain_row, x_rd_addr, w_rd_addr}), 128'd0);
    next_cycle();
    rst = 1'b0;
    wait_to(t0 + 16);
    check("rst_no_done", 128'({busy, 8'(done_cnt - dc0)}), 128'd0);
    next_cycle();
    prep_job(1);
    t0 = cyc;
    start_cmd(1);
    wait_to(t0 + 16);
    check("k1_t16", 128'({busy, done}), 128'b10);
    wait_to(t0 + 17);
    check("k1_done_t17", 128'({busy, done}), 128'b01);

    // randomized depths with random backpressure, then the full depth
    for (int j = 0; j < 6; j++) begin
      next_cycle();
      run_job($urandom_range(1, 24), 1'b1);
    end
    next_cycle();
    run_job(MAX_K, 1'b0);
    next_cycle();
    run_job(MAX_K, 1'b1);

    repeat (3) next_cycle();
    check("final_sb_empty", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
